calcu_loader: RTL and testbench

CALCU_LOADER -- requirements
Module: calcu_loader

---
 rtl/calcu_pkg.sv | 32 +++
 rtl/calcu_phase_timer.sv | 29 ++
 rtl/calcu_loader.sv | 156 +++++++++++++++
 tb/tb_calcu_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcu_pkg.sv
// Shared definitions for the calculator loader: FSM states, processor memory map, strobe polarity.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: CALCU_LOADER_OPCLEAR_EN adds the CLR state (opcode word cleared after use).
package calcu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    GAP_A,
    WR_B,
    GAP_B,
    WR_OP,
    WAIT,
`ifdef CALCU_LOADER_OPCLEAR_EN
    CLR,
`endif
    DONE
  } calcuState_t;

  // Processor data-memory map
  localparam logic [31:0] ADDR_OPCODE = 32'd0;
  localparam logic [31:0] ADDR_OP_A   = 32'd16;
  localparam logic [31:0] ADDR_OP_B   = 32'd20;

  // Processor write strobe is active-low
  localparam logic WE_ACTIVE = 1'b0;
  localparam logic WE_IDLE   = 1'b1;

  localparam int PHASE_W = 8;

endpackage

// File: rtl/calcu_phase_timer.sv
// Phase timer: loadable 8-bit down-counter that stops at zero and flags it.
// Latency: load value visible the cycle after the load edge; zero flag is combinational on the count.
// Backpressure: none; load has priority over counting.
// Ports: CLK/RST clock and async active-high reset, load/loadVal reload request and value, zero flag out.
module calcu_phase_timer
  import calcu_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic [PHASE_W-1:0] loadVal,
  output logic               zero
);

  logic [PHASE_W-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/calcu_loader.sv
// Calculator loader: writes op_a, op_b and opcode into processor memory, waits, then captures the result.
// Latency: done pulses 5*HOLD_CYCLES+WAIT_CYCLES+1 cycles after start acceptance (6*HOLD+WAIT+1 with CALCU_LOADER_OPCLEAR_EN).
// Backpressure: none; start is only sampled in IDLE, busy flags an active sequence.
// Ports: CLK, RST (async active-high); start/op_a/op_b/opcode request; resultadoCalcu from processor;
//        EntradaCalcu/addressCalcu/writeEnableCalcu (active-low) to processor; busy, done, result status.
// Optional feature macro: CALCU_LOADER_OPCLEAR_EN writes 0 to the opcode address after the wait phase.
module calcu_loader
  import calcu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned WAIT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] opcode,
  input  logic [31:0] resultadoCalcu,
  output logic [31:0] EntradaCalcu,
  output logic [31:0] addressCalcu,
  output logic        writeEnableCalcu,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  // Counter is reloaded with duration-1 on entry, so each phase lasts exactly its duration
  localparam logic [PHASE_W-1:0] HOLD_LOAD = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] WAIT_LOAD = PHASE_W'(WAIT_CYCLES - 1);

  calcuState_t        state;
  calcuState_t        stateNext;
  logic               phaseZero;
  logic               phaseLoad;
  logic [PHASE_W-1:0] phaseLoadVal;
  logic [31:0]        opAReg;
  logic [31:0]        opBReg;
  logic [31:0]        opcodeReg;

  calcu_phase_timer phaseTimer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (phaseLoad),
    .loadVal (phaseLoadVal),
    .zero    (phaseZero)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and the phase length to load on entry to it
  always_comb begin
    stateNext    = state;
    phaseLoadVal = '0;
    case (state)
      IDLE:  if (start)     stateNext = WR_A;
      WR_A:  if (phaseZero) stateNext = GAP_A;
      GAP_A: if (phaseZero) stateNext = WR_B;
      WR_B:  if (phaseZero) stateNext = GAP_B;
      GAP_B: if (phaseZero) stateNext = WR_OP;
      WR_OP: if (phaseZero) stateNext = WAIT;
`ifdef CALCU_LOADER_OPCLEAR_EN
      WAIT:  if (phaseZero) stateNext = CLR;
      CLR:   if (phaseZero) stateNext = DONE;
`else
      WAIT:  if (phaseZero) stateNext = DONE;
`endif
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    case (stateNext)
      WR_A, GAP_A, WR_B, GAP_B, WR_OP: phaseLoadVal = HOLD_LOAD;
`ifdef CALCU_LOADER_OPCLEAR_EN
      CLR:                             phaseLoadVal = HOLD_LOAD;
`endif
      WAIT:                            phaseLoadVal = WAIT_LOAD;
      default:                         phaseLoadVal = '0;
    endcase
  end

  assign phaseLoad = (stateNext != state);

  // Moore outputs decoded from the state register, so an async reset releases the strobe at once
  always_comb begin
    EntradaCalcu     = '0;
    addressCalcu     = '0;
    writeEnableCalcu = WE_IDLE;
    busy             = 1'b1;
    done             = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      WR_A: begin
        addressCalcu     = ADDR_OP_A;
        EntradaCalcu     = opAReg;
        writeEnableCalcu = WE_ACTIVE;
      end
      GAP_A: begin
        addressCalcu = ADDR_OP_A;
        EntradaCalcu = opAReg;
      end
      WR_B: begin
        addressCalcu     = ADDR_OP_B;
        EntradaCalcu     = opBReg;
        writeEnableCalcu = WE_ACTIVE;
      end
      GAP_B: begin
        addressCalcu = ADDR_OP_B;
        EntradaCalcu = opBReg;
      end
      WR_OP: begin
        addressCalcu     = ADDR_OPCODE;
        EntradaCalcu     = opcodeReg;
        writeEnableCalcu = WE_ACTIVE;
      end
`ifdef CALCU_LOADER_OPCLEAR_EN
      CLR: begin
        addressCalcu     = ADDR_OPCODE;
        writeEnableCalcu = WE_ACTIVE;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operands are frozen at acceptance so later input changes cannot corrupt the sequence
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opAReg    <= '0;
      opBReg    <= '0;
      opcodeReg <= '0;
    end else if (state == IDLE && start) begin
      opAReg    <= op_a;
      opBReg    <= op_b;
      opcodeReg <= opcode;
    end
  end

  // Result sampled on the final edge of the wait phase and held until the next capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result <= '0;
    end else if (state == WAIT && phaseZero) begin
      result <= resultadoCalcu;
    end
  end

endmodule

// File: tb/tb_calcu_loader.sv
module tb_calcu_loader;

`ifdef CALCU_LOADER_OPCLEAR_EN
  localparam int CLRN = 1;
`else
  localparam int CLRN = 0;
`endif
  localparam int H    = 10;
  localparam int W    = 16;
  localparam int LAT  = (5 + CLRN) * H + W + 1;
  localparam int LATF = (5 + CLRN) * 1 + 1 + 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int nCmp = 0;
  int nBad = 0;

  // Default-parameter instance
  logic        start = 1'b0;
  logic [31:0] opA = '0, opB = '0, opcode = '0;
  logic [31:0] resIn, entrada, addr, result;
  logic        we, busy, done;

  // HOLD_CYCLES=1, WAIT_CYCLES=1 instance
  logic        startF = 1'b0;
  logic [31:0] opAF = '0, opBF = '0, opcodeF = '0;
  logic [31:0] resInF, entradaF, addrF, resultF;
  logic        weF, busyF, doneF;

  calcu_loader dut (
    .CLK(CLK), .RST(RST), .start(start), .op_a(opA), .op_b(opB), .opcode(opcode),
    .resultadoCalcu(resIn), .EntradaCalcu(entrada), .addressCalcu(addr),
    .writeEnableCalcu(we), .busy(busy), .done(done), .result(result)
  );

  calcu_loader #(.HOLD_CYCLES(1), .WAIT_CYCLES(1)) dutFast (
    .CLK(CLK), .RST(RST), .start(startF), .op_a(opAF), .op_b(opBF), .opcode(opcodeF),
    .resultadoCalcu(resInF), .EntradaCalcu(entradaF), .addressCalcu(addrF),
    .writeEnableCalcu(weF), .busy(busyF), .done(doneF), .result(resultF)
  );

  // Reference arithmetic of the processor
  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    logic [31:0] r;
    case (op[1:0])
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a + b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  // Processor model: data memory written on active-low strobe, result computed from memory
  logic [31:0] memA = '0, memB = '0, memOp = '0;
  logic [31:0] memAF = '0, memBF = '0, memOpF = '0;
  always @(posedge CLK) begin
    if (!we) begin
      if (addr == 32'd16) memA <= entrada;
      if (addr == 32'd20) memB <= entrada;
      if (addr == 32'd0)  memOp <= entrada;
    end
    if (!weF) begin
      if (addrF == 32'd16) memAF <= entradaF;
      if (addrF == 32'd20) memBF <= entradaF;
      if (addrF == 32'd0)  memOpF <= entradaF;
    end
  end
  assign resIn  = calc(memA, memB, memOp);
  assign resInF = calc(memAF, memBF, memOpF);

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nCmp++;
    if (we !== 1'b1 || addr !== 32'd0 || entrada !== 32'd0) begin
      nBad++;
      $display("FAIL reset_bus: we=%b addr=%0d dat=%h, required we=1 addr=0 dat=0", we, addr, entrada);
    end
    nCmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      nBad++;
      $display("FAIL reset_status: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
    end
    nCmp++;
    if (weF !== 1'b1 || busyF !== 1'b0 || doneF !== 1'b0 || resultF !== 32'd0) begin
      nBad++;
      $display("FAIL reset_fast: we=%b busy=%b done=%b result=%h, required 1 0 0 0", weF, busyF, doneF, resultF);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  // Full bus trace of one sequence on the default instance, cycle by cycle
  task automatic test_sequence(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    logic [31:0] expDat, expAddr;
    logic        expWe;
    @(posedge CLK); #1;
    opA = a; opB = b; opcode = op; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge CLK);
      expWe = 1'b1; expAddr = 32'd0; expDat = 32'd0;
      if (k <= 5 * H) begin
        case ((k - 1) / H)
          0: begin expWe = 1'b0; expAddr = 32'd16; expDat = a; end
          1: begin expWe = 1'b1; expAddr = 32'd16; expDat = a; end
          2: begin expWe = 1'b0; expAddr = 32'd20; expDat = b; end
          3: begin expWe = 1'b1; expAddr = 32'd20; expDat = b; end
          default: begin expWe = 1'b0; expAddr = 32'd0; expDat = op; end
        endcase
      end else if (CLRN == 1 && k > 5 * H + W && k <= 6 * H + W) begin
        expWe = 1'b0;
      end
      nCmp++;
      if (we !== expWe || addr !== expAddr || entrada !== expDat) begin
        nBad++;
        $display("FAIL seq_bus cycle %0d: we=%b addr=%0d dat=%h, required we=%b addr=%0d dat=%h",
                 k, we, addr, entrada, expWe, expAddr, expDat);
      end
      nCmp++;
      if (done !== (k == LAT)) begin
        nBad++;
        $display("FAIL seq_done cycle %0d: done=%b, required %b", k, done, (k == LAT));
      end
      nCmp++;
      if (busy !== (k <= LAT)) begin
        nBad++;
        $display("FAIL seq_busy cycle %0d: busy=%b, required %b", k, busy, (k <= LAT));
      end
      if (k == LAT) begin
        nCmp++;
        if (result !== calc(a, b, op)) begin
          nBad++;
          $display("FAIL seq_result: result=%h, required %h", result, calc(a, b, op));
        end
      end
      // Inputs change after acceptance; the written words must not follow them
      if (k == 1) begin
        opA = $urandom; opB = $urandom; opcode = $urandom;
      end
    end
    repeat (6) @(negedge CLK);
    nCmp++;
    if (result !== calc(a, b, op)) begin
      nBad++;
      $display("FAIL seq_result_hold: result=%h, required %h", result, calc(a, b, op));
    end
    nCmp++;
    if (memOp !== (CLRN == 1 ? 32'd0 : op)) begin
      nBad++;
      $display("FAIL seq_opcode_word: mem[0]=%h, required %h", memOp, (CLRN == 1 ? 32'd0 : op));
    end
  endtask

  task automatic test_ignore_start;
    int doneCnt = 0;
    logic [31:0] a = $urandom, b = $urandom, op = $urandom;
    @(posedge CLK); #1;
    opA = a; opB = b; opcode = op; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        doneCnt++;
        nCmp++;
        if (k != LAT) begin
          nBad++;
          $display("FAIL ignore_done_time: done at cycle %0d, required %0d", k, LAT);
        end
      end
      if (k > LAT) begin
        nCmp++;
        if (busy !== 1'b0) begin
          nBad++;
          $display("FAIL ignore_busy cycle %0d: busy=%b, required 0", k, busy);
        end
      end
      if (k == 2 * H + 3) begin start = 1'b1; opA = ~a; end
      if (k == 2 * H + 4) start = 1'b0;
      if (k == LAT) start = 1'b1;
      if (k == LAT + 1) start = 1'b0;
    end
    nCmp++;
    if (doneCnt != 1) begin
      nBad++;
      $display("FAIL ignore_done_count: %0d done pulses, required 1", doneCnt);
    end
    nCmp++;
    if (result !== calc(a, b, op)) begin
      nBad++;
      $display("FAIL ignore_result: result=%h, required %h", result, calc(a, b, op));
    end
  endtask

  task automatic test_reset_mid;
    int doneCnt = 0;
    int busyCnt = 0;
    @(posedge CLK); #1;
    opA = $urandom; opB = $urandom; opcode = $urandom; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 1; k <= 4 * H + 3; k++) @(negedge CLK);
    nCmp++;
    if (we !== 1'b0 || addr !== 32'd0) begin
      nBad++;
      $display("FAIL rstmid_pre: we=%b addr=%0d, required we=0 addr=0", we, addr);
    end
    #2 RST = 1'b1;
    #1;
    nCmp++;
    if (we !== 1'b1 || busy !== 1'b0 || entrada !== 32'd0) begin
      nBad++;
      $display("FAIL rstmid_cut: we=%b busy=%b dat=%h, required we=1 busy=0 dat=0", we, busy, entrada);
    end
    nCmp++;
    if (result !== 32'd0 || done !== 1'b0) begin
      nBad++;
      $display("FAIL rstmid_result: result=%h done=%b, required 0 0", result, done);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge CLK);
      if (done === 1'b1) doneCnt++;
      if (busy === 1'b1) busyCnt++;
    end
    nCmp++;
    if (doneCnt != 0 || busyCnt != 0) begin
      nBad++;
      $display("FAIL rstmid_after: done pulses=%0d busy cycles=%0d, required 0 0", doneCnt, busyCnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1 = $urandom, b1 = $urandom, o1 = $urandom;
    logic [31:0] a2 = $urandom, b2 = $urandom, o2 = $urandom;
    int  j;
    logic expWe, expDone, expBusy;
    @(posedge CLK); #1;
    opAF = a1; opBF = b1; opcodeF = o1; startF = 1'b1;
    @(posedge CLK); #1;
    startF = 1'b0;
    for (int k = 1; k <= 2 * LATF + 3; k++) begin
      @(negedge CLK);
      j = (k <= LATF) ? k : k - (LATF + 1);
      expWe   = !(j == 1 || j == 3 || j == 5 || (CLRN == 1 && j == 7));
      expDone = (k == LATF) || (k == 2 * LATF + 1);
      expBusy = (k <= LATF) || (k >= LATF + 2 && k <= 2 * LATF + 1);
      nCmp++;
      if (weF !== expWe || doneF !== expDone || busyF !== expBusy) begin
        nBad++;
        $display("FAIL b2b cycle %0d: we=%b done=%b busy=%b, required we=%b done=%b busy=%b",
                 k, weF, doneF, busyF, expWe, expDone, expBusy);
      end
      if (k == LATF) begin
        nCmp++;
        if (resultF !== calc(a1, b1, o1)) begin
          nBad++;
          $display("FAIL b2b_result1: result=%h, required %h", resultF, calc(a1, b1, o1));
        end
      end
      if (k == 2 * LATF + 1) begin
        nCmp++;
        if (resultF !== calc(a2, b2, o2)) begin
          nBad++;
          $display("FAIL b2b_result2: result=%h, required %h", resultF, calc(a2, b2, o2));
        end
      end
      if (k == LATF + 1) begin
        opAF = a2; opBF = b2; opcodeF = o2; startF = 1'b1;
      end
      if (k == LATF + 2) begin
        startF = 1'b0; opAF = $urandom; opBF = $urandom; opcodeF = $urandom;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence(32'd7, 32'd8, 32'd2);
    for (int i = 0; i < 3; i++) test_sequence($urandom, $urandom, $urandom);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
